// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, FSM states,
// PC-source selects and fault codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LD   = 4'd1;
    localparam logic [3:0] OP_ST   = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_ADDI = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE        = 2'b00;
    localparam logic [1:0] FAULT_MEM_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL     = 2'b10;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'd12) && (op <= 4'd14);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Instruction/data memory req/ready handshake bundle between the sequencer
// (master) and the memory side (slave).
interface cpu_seq_ctrl_if #(
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic               imem_ready;
    logic [INSTR_W-1:0] instr_in;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, instr_in, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, instr_in, dmem_ready
    );
endinterface

// File: rtl/cpu_seq_ctrl_mem_wait_timer.sv
// Memory wait counter shared by FETCH and MEM: counts not-ready cycles and
// flags a timeout when the limit is reached while still not ready.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] r_count;
    logic          w_at_limit;
    logic          w_waiting;

    assign w_at_limit = (r_count == CW'(MEM_TIMEOUT));
    assign w_waiting  = i_active && !i_ready;
    assign o_timeout  = w_waiting && w_at_limit;

    // Any cycle that is not a wait clears the count, so entry to FETCH/MEM starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!w_waiting) begin
            r_count <= '0;
        end else if (!w_at_limit) begin
            r_count <= r_count + CW'(1);
        end
    end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the 4-bit-opcode core.
// Optional macro CPU_ILLEGAL_TRAP_EN: opcodes 12-14 fault instead of executing as NOP.
module cpu_seq_ctrl #(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 zero_flag,
    cpu_seq_ctrl_if.master       mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic [3:0]           alu_ctrl_in,
    output logic                 alu_src_imm,
    output logic                 reg_we,
    output logic                 wb_sel_mem,
    output logic                 instr_done,
    output logic                 halted,
    output logic [1:0]           fault_code
);
    import cpu_ctrl_pkg::*;

`ifdef CPU_ILLEGAL_TRAP_EN
    localparam logic ILLEGAL_TRAP = 1'b1;
`else
    localparam logic ILLEGAL_TRAP = 1'b0;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_opcode;
    logic       r_imem_req;
    logic       r_dmem_req;
    logic       r_dmem_we;
    logic [3:0] r_alu_ctrl;
    logic       r_alu_src_imm;
    logic       r_reg_we;
    logic       r_wb_sel_mem;
    logic       r_halted;
    logic [1:0] r_fault_code;
    logic       w_wait_active;
    logic       w_wait_ready;
    logic       w_timeout;

    assign w_wait_active = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_wait_ready  = (r_state == S_FETCH) ? mem.imem_ready : mem.dmem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_wait_active),
        .i_ready   (w_wait_ready),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (start) w_next = S_FETCH;
            S_FETCH: begin
                if (mem.imem_ready)  w_next = S_DECODE;
                else if (w_timeout)  w_next = S_FAULT;
            end
            S_DECODE: begin
                if (r_opcode == OP_NOP || r_opcode == OP_JMP) w_next = S_FETCH;
                else if (r_opcode == OP_HALT)                 w_next = S_HALT;
                else if (is_illegal_op(r_opcode))             w_next = ILLEGAL_TRAP ? S_FAULT : S_FETCH;
                else                                          w_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_branch_op(r_opcode))   w_next = S_FETCH;
                else if (is_mem_op(r_opcode)) w_next = S_MEM;
                else                          w_next = S_WRITEBACK;
            end
            S_MEM: begin
                if (mem.dmem_ready)  w_next = (r_opcode == OP_ST) ? S_FETCH : S_WRITEBACK;
                else if (w_timeout)  w_next = S_FAULT;
            end
            S_WRITEBACK: w_next = S_FETCH;
            default:     w_next = r_state;
        endcase
    end

    // Moore outputs are registered from the next state so they are valid for the whole state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_imem_req    <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_alu_ctrl    <= '0;
            r_alu_src_imm <= 1'b0;
            r_reg_we      <= 1'b0;
            r_wb_sel_mem  <= 1'b0;
            r_halted      <= 1'b0;
            r_fault_code  <= FAULT_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && mem.imem_ready) begin
                r_opcode <= mem.instr_in[INSTR_W-1 -: 4];
            end
            r_imem_req    <= (w_next == S_FETCH);
            r_dmem_req    <= (w_next == S_MEM);
            r_dmem_we     <= (w_next == S_MEM) && (r_opcode == OP_ST);
            r_alu_ctrl    <= (w_next != S_EXECUTE) ? 4'd0 :
                             (is_mem_op(r_opcode) ? OP_ADD : r_opcode);
            r_alu_src_imm <= (w_next == S_EXECUTE) &&
                             (is_mem_op(r_opcode) || r_opcode == OP_ADDI);
            r_reg_we      <= (w_next == S_WRITEBACK);
            r_wb_sel_mem  <= (w_next == S_WRITEBACK) && (r_opcode == OP_LD);
            r_halted      <= (w_next == S_HALT);
            if (r_state != S_FAULT && w_next == S_FAULT) begin
                r_fault_code <= (r_state == S_DECODE) ? FAULT_ILLEGAL : FAULT_MEM_TIMEOUT;
            end
        end
    end

    always_comb begin
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        instr_done = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                ir_we = mem.imem_ready;
                pc_we = mem.imem_ready;
            end
            S_DECODE: begin
                if (r_opcode == OP_JMP) begin
                    pc_we      = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    instr_done = 1'b1;
                end else if (r_opcode == OP_NOP ||
                             (is_illegal_op(r_opcode) && !ILLEGAL_TRAP)) begin
                    instr_done = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (is_branch_op(r_opcode)) begin
                    pc_src     = PC_SRC_BRANCH;
                    pc_we      = (r_opcode == OP_BEQ) ? zero_flag : !zero_flag;
                    instr_done = 1'b1;
                end
            end
            S_MEM:       instr_done = mem.dmem_ready && (r_opcode == OP_ST);
            S_WRITEBACK: instr_done = 1'b1;
            default:     instr_done = 1'b0;
        endcase
    end

    assign mem.imem_req = r_imem_req;
    assign mem.dmem_req = r_dmem_req;
    assign mem.dmem_we  = r_dmem_we;
    assign alu_ctrl_in  = r_alu_ctrl;
    assign alu_src_imm  = r_alu_src_imm;
    assign reg_we       = r_reg_we;
    assign wb_sel_mem   = r_wb_sel_mem;
    assign halted       = r_halted;
    assign fault_code   = r_fault_code;
endmodule
